// File: rtl/layer_sched_if.sv
// Engine/DRAM bus of the layer sequencer: launch pulses and done strobes per engine,
// the packed engine memory requests, and the single muxed DRAM port.
interface layer_sched_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int NUM_ENG    = 4
);
  logic [NUM_ENG-1:0]            eng_enable;
  logic [NUM_ENG-1:0]            eng_done;
  logic [NUM_ENG*ADDR_WIDTH-1:0] eng_addr_in;
  logic [NUM_ENG*ADDR_WIDTH-1:0] eng_addr_out;
  logic [NUM_ENG*DATA_WIDTH-1:0] eng_data_out;
  logic [NUM_ENG-1:0]            eng_en_rd;
  logic [NUM_ENG-1:0]            eng_en_wr;
  logic [ADDR_WIDTH-1:0]         dram_addr_rd;
  logic [ADDR_WIDTH-1:0]         dram_addr_wr;
  logic [DATA_WIDTH-1:0]         dram_wdata;
  logic                          dram_en_rd;
  logic                          dram_en_wr;

  modport master (
    output eng_enable, dram_addr_rd, dram_addr_wr, dram_wdata, dram_en_rd, dram_en_wr,
    input  eng_done, eng_addr_in, eng_addr_out, eng_data_out, eng_en_rd, eng_en_wr
  );

  modport slave (
    input  eng_enable, dram_addr_rd, dram_addr_wr, dram_wdata, dram_en_rd, dram_en_wr,
    output eng_done, eng_addr_in, eng_addr_out, eng_data_out, eng_en_rd, eng_en_wr
  );
endinterface

// File: rtl/layer_sched.sv
// Layer sequencer: walks the programmed engine table, launches each engine, waits for its
// done (with a watchdog) and hands the selected engine the shared DRAM port meanwhile.
module layer_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int NUM_ENG    = 4,
  parameter int MAX_LAYERS = 16,
  parameter int TIMEOUT    = 1048576,
  localparam int EW = $clog2(NUM_ENG),
  localparam int LW = $clog2(MAX_LAYERS)
) (
  input  logic          clk,
  input  logic          srstn,
  input  logic          cfg_we,
  input  logic [LW-1:0] cfg_idx,
  input  logic [EW-1:0] cfg_eng,
  input  logic [LW:0]   num_layers,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [LW-1:0] cur_layer,
  layer_sched_if.master bus
);

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    LAUNCH = 5'b00010,
    RUN    = 5'b00100,
    NEXT   = 5'b01000,
    FIN    = 5'b10000
  } state_t;

  localparam logic [20:0] WD_LIMIT = 21'(TIMEOUT - 1);
  localparam logic [20:0] WD_MAX   = {21{1'b1}};
  localparam logic [LW:0] MAX_N    = (LW+1)'(MAX_LAYERS);
  localparam logic [LW:0] ONE_N    = {{LW{1'b0}}, 1'b1};
  localparam logic [LW-1:0] ONE_L  = {{(LW-1){1'b0}}, 1'b1};

  state_t               state_r;
  logic [EW-1:0]        tbl_r [MAX_LAYERS];
  logic [LW:0]          n_lat_r;
  logic [EW-1:0]        sel_r;
  logic [20:0]          wd_r;
  logic [NUM_ENG-1:0]   eng_en_r;
  logic [LW:0]          clamp_s;
  logic [EW-1:0]        first_eng_s;
  logic [EW-1:0]        next_eng_s;
  logic                 live_s;

  function automatic logic [NUM_ENG-1:0] onehot_f(input logic [EW-1:0] e);
    onehot_f = {{(NUM_ENG-1){1'b0}}, 1'b1} << e;
  endfunction

  assign bus.eng_enable = eng_en_r;

  // Table writes are accepted only while idle, so a running sequence sees a frozen table.
  always_ff @(posedge clk) begin
    if (cfg_we && (state_r == IDLE)) begin
      tbl_r[cfg_idx] <= cfg_eng;
    end
  end

  // Start-time helpers: layer-count clamp and a bypass so a same-cycle write to entry 0 launches.
  always_comb begin
    clamp_s     = (num_layers > MAX_N) ? MAX_N : num_layers;
    first_eng_s = (cfg_we && (cfg_idx == {LW{1'b0}})) ? cfg_eng : tbl_r[0];
    next_eng_s  = tbl_r[cur_layer + ONE_L];
    live_s      = (state_r == LAUNCH) || (state_r == RUN) || (state_r == NEXT);
  end

  // Sequencer state, watchdog and all registered status outputs.
  always_ff @(posedge clk) begin
    if (srstn) begin
      state_r   <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cur_layer <= '0;
      n_lat_r   <= '0;
      sel_r     <= '0;
      wd_r      <= '0;
      eng_en_r  <= '0;
    end else begin
      done     <= 1'b0;
      eng_en_r <= '0;
      case (state_r)
        IDLE: begin
          if (start) begin
            err       <= 1'b0;
            busy      <= 1'b1;
            cur_layer <= '0;
            n_lat_r   <= clamp_s;
            if (clamp_s == {(LW+1){1'b0}}) begin
              state_r <= FIN;
              done    <= 1'b1;
            end else begin
              state_r  <= LAUNCH;
              sel_r    <= first_eng_s;
              eng_en_r <= onehot_f(first_eng_s);
            end
          end
        end
        LAUNCH: begin
          wd_r    <= '0;
          state_r <= RUN;
        end
        RUN: begin
          if (bus.eng_done[sel_r]) begin
            state_r <= NEXT;
          end else if (wd_r == WD_LIMIT) begin
            err     <= 1'b1;
            done    <= 1'b1;
            state_r <= FIN;
          end else if (wd_r != WD_MAX) begin
            wd_r <= wd_r + 21'd1;
          end
        end
        NEXT: begin
          if ({1'b0, cur_layer} == (n_lat_r - ONE_N)) begin
            done    <= 1'b1;
            state_r <= FIN;
          end else begin
            cur_layer <= cur_layer + ONE_L;
            sel_r     <= next_eng_s;
            eng_en_r  <= onehot_f(next_eng_s);
            state_r   <= LAUNCH;
          end
        end
        FIN: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // DRAM port follows the selected engine from launch through the drain cycle after its done.
  always_comb begin
    bus.dram_addr_rd = '0;
    bus.dram_addr_wr = '0;
    bus.dram_wdata   = '0;
    bus.dram_en_rd   = 1'b0;
    bus.dram_en_wr   = 1'b0;
    if (live_s) begin
      bus.dram_addr_rd = bus.eng_addr_in[int'(sel_r)*ADDR_WIDTH +: ADDR_WIDTH];
      bus.dram_addr_wr = bus.eng_addr_out[int'(sel_r)*ADDR_WIDTH +: ADDR_WIDTH];
      bus.dram_wdata   = bus.eng_data_out[int'(sel_r)*DATA_WIDTH +: DATA_WIDTH];
      bus.dram_en_rd   = bus.eng_en_rd[sel_r];
      bus.dram_en_wr   = bus.eng_en_wr[sel_r];
    end else begin
      bus.dram_en_rd   = 1'b0;
      bus.dram_en_wr   = 1'b0;
    end
  end

endmodule

// File: tb/tb_layer_sched.sv
// Randomized bench for layer_sched: a schedule model predicts launch, done and DRAM-ownership
// cycles from the table contents and engine latencies.
module tb_layer_sched;
  localparam int AW = 18;
  localparam int DW = 32;
  localparam int NE = 4;
  localparam int ML = 16;
  localparam int TO = 64;

  logic       clk = 1'b0;
  logic       srstn;
  logic       cfg_we;
  logic [3:0] cfg_idx;
  logic [1:0] cfg_eng;
  logic [4:0] num_layers;
  logic       start;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] cur_layer;

  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;
  logic [1:0] tbl_m [ML];
  int         lat_m [ML];

  layer_sched_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_ENG(NE)) bus ();

  layer_sched #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_ENG(NE), .MAX_LAYERS(ML), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .srstn(srstn), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_eng(cfg_eng),
    .num_layers(num_layers), .start(start), .busy(busy), .done(done), .err(err),
    .cur_layer(cur_layer), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic rand_bus();
    bus.eng_addr_in  = 72'({$urandom(), $urandom(), $urandom()});
    bus.eng_addr_out = 72'({$urandom(), $urandom(), $urandom()});
    bus.eng_data_out = {$urandom(), $urandom(), $urandom(), $urandom()};
    bus.eng_en_rd    = 4'($urandom_range(0, 15));
    bus.eng_en_wr    = 4'($urandom_range(0, 15));
  endtask

  task automatic idle_inputs();
    start = 1'b0; cfg_we = 1'b0; cfg_idx = 4'd0; cfg_eng = 2'd0; num_layers = 5'd0;
    bus.eng_done = 4'd0;
  endtask

  function automatic logic [69:0] dram_exp(input int k);
    dram_exp = {bus.eng_addr_in[k*AW +: AW], bus.eng_addr_out[k*AW +: AW],
                bus.eng_data_out[k*DW +: DW], bus.eng_en_rd[k], bus.eng_en_wr[k]};
  endfunction

  task automatic write_tbl(input int idx, input logic [1:0] eng);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 4'(idx); cfg_eng = eng;
    tbl_m[idx] = eng;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // One full sequence; garbage start/cfg/num_layers while busy, spurious done on idle engines.
  task automatic run_seq(input int n_req, input bit cfg_at_start, input bit force_idx0);
    int n, s, fin, seen, pend_c, act, run_eng;
    int e [ML];
    int d [ML];
    logic [1:0]  eng_m [ML];
    logic [3:0]  want_en, pend_v, noise;
    logic [69:0] got70, want70;
    n = (n_req > ML) ? ML : n_req;
    @(negedge clk);
    s = cyc;
    start = 1'b1; num_layers = 5'(n_req);
    cfg_we = cfg_at_start; cfg_idx = 4'd0; cfg_eng = 2'($urandom_range(0, 3));
    if (cfg_at_start) tbl_m[0] = cfg_eng;
    bus.eng_done = 4'd0;
    rand_bus();
    for (int i = 0; i < n; i++) begin
      eng_m[i] = tbl_m[i];
      e[i] = (i == 0) ? s + 1 : d[i-1] + 2;
      d[i] = e[i] + lat_m[i];
    end
    fin = (n == 0) ? s + 1 : d[n-1] + 2;
    seen = 0; pend_c = -1; pend_v = 4'd0;
    for (int c = s + 1; c <= fin + 1; c++) begin
      @(negedge clk);
      want_en = 4'd0; act = -1; run_eng = -1;
      for (int i = 0; i < n; i++) begin
        if (e[i] == c) want_en = 4'b0001 << eng_m[i];
        if (c >= e[i] && c <= d[i] + 1) act = i;
        if (c > e[i] && c <= d[i]) run_eng = int'(eng_m[i]);
      end
      n_vec++;
      if (bus.eng_enable !== want_en) begin
        n_err++; $display("FAIL eng_enable @%0d: got %b want %b", c - s, bus.eng_enable, want_en);
      end
      n_vec++;
      if (done !== (c == fin)) begin
        n_err++; $display("FAIL done @%0d: got %b want %b", c - s, done, (c == fin));
      end
      n_vec++;
      if (busy !== (c <= fin)) begin
        n_err++; $display("FAIL busy @%0d: got %b want %b", c - s, busy, (c <= fin));
      end
      n_vec++;
      if (err !== 1'b0) begin
        n_err++; $display("FAIL err_run @%0d: got %b want 0", c - s, err);
      end
      if (act >= 0) begin
        n_vec++;
        if (cur_layer !== 4'(act)) begin
          n_err++; $display("FAIL cur_layer @%0d: got %0d want %0d", c - s, cur_layer, act);
        end
      end
      got70  = {bus.dram_addr_rd, bus.dram_addr_wr, bus.dram_wdata, bus.dram_en_rd, bus.dram_en_wr};
      want70 = (act >= 0) ? dram_exp(int'(eng_m[act])) : 70'd0;
      n_vec++;
      if (got70 !== want70) begin
        n_err++; $display("FAIL dram_mux @%0d: got %h want %h", c - s, got70, want70);
      end
      if (bus.eng_enable !== 4'd0 && seen < ML) begin
        pend_c = c + lat_m[seen]; pend_v = bus.eng_enable; seen++;
      end
      noise = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      if (run_eng >= 0) noise = noise & ~(4'b0001 << run_eng);
      if (c <= fin) begin
        start = 1'($urandom_range(0, 1)); num_layers = 5'($urandom_range(0, 31));
        cfg_we = 1'($urandom_range(0, 1));
        cfg_idx = force_idx0 ? 4'd0 : 4'($urandom_range(0, 15));
        cfg_eng = 2'($urandom_range(0, 3));
        bus.eng_done = ((c == pend_c) ? pend_v : 4'd0) | noise;
      end else begin
        idle_inputs();
      end
      rand_bus();
    end
    n_vec++;
    if (seen !== n) begin
      n_err++; $display("FAIL launch_count: got %0d want %0d", seen, n);
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    logic [69:0] got70;
    srstn = 1'b1; idle_inputs(); rand_bus();
    bus.eng_en_rd = 4'hF; bus.eng_en_wr = 4'hF;
    repeat (3) @(negedge clk);
    got70 = {bus.dram_addr_rd, bus.dram_addr_wr, bus.dram_wdata, bus.dram_en_rd, bus.dram_en_wr};
    n_vec++;
    if ({busy, done, err, bus.eng_enable, cur_layer} !== 11'd0 || got70 !== 70'd0) begin
      n_err++; $display("FAIL reset_state: got %b/%h want 0/0",
                        {busy, done, err, bus.eng_enable, cur_layer}, got70);
    end
    srstn = 1'b0;
  endtask

  task automatic program_table();
    for (int i = 0; i < ML; i++) write_tbl(i, 2'($urandom_range(0, 3)));
  endtask

  task automatic test_basic();
    write_tbl(0, 2'd2); write_tbl(1, 2'd1); write_tbl(2, 2'd0);
    for (int i = 0; i < ML; i++) lat_m[i] = 5;
    run_seq(3, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < ML; i++) lat_m[i] = $urandom_range(1, 6);
      run_seq($urandom_range(0, 20), 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  task automatic test_cfg_frozen();
    run_seq(2, 1'b0, 1'b1);
    run_seq(2, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    int s, fin;
    logic [3:0] want_en;
    @(negedge clk);
    s = cyc; start = 1'b1; num_layers = 5'd1; bus.eng_done = 4'd0;
    fin = s + 2 + TO;
    for (int c = s + 1; c <= fin + 4; c++) begin
      @(negedge clk);
      want_en = (c == s + 1) ? (4'b0001 << tbl_m[0]) : 4'd0;
      n_vec++;
      if (bus.eng_enable !== want_en) begin
        n_err++; $display("FAIL to_enable @%0d: got %b want %b", c - s, bus.eng_enable, want_en);
      end
      n_vec++;
      if (done !== (c == fin) || err !== (c >= fin) || busy !== (c <= fin)) begin
        n_err++; $display("FAIL timeout @%0d: got done/err/busy=%b%b%b want %b%b%b", c - s,
                          done, err, busy, (c == fin), (c >= fin), (c <= fin));
      end
      start = 1'b0;
      bus.eng_done = 4'($urandom_range(0, 15)) & ~(4'b0001 << tbl_m[0]);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    int s;
    logic [69:0] got70;
    @(negedge clk);
    s = cyc; start = 1'b1; num_layers = 5'd3; bus.eng_done = 4'd0; rand_bus();
    for (int c = s + 1; c <= s + 7; c++) begin
      @(negedge clk);
      if (c == s + 6) begin
        n_vec++;
        if (busy !== 1'b1 || cur_layer !== 4'd1) begin
          n_err++; $display("FAIL pre_reset: got busy=%b layer=%0d want 1/1", busy, cur_layer);
        end
      end
      if (c == s + 7) begin
        got70 = {bus.dram_addr_rd, bus.dram_addr_wr, bus.dram_wdata, bus.dram_en_rd, bus.dram_en_wr};
        n_vec++;
        if ({busy, done, err, bus.eng_enable, cur_layer} !== 11'd0 || got70 !== 70'd0) begin
          n_err++; $display("FAIL mid_reset: got %b/%h want 0/0",
                            {busy, done, err, bus.eng_enable, cur_layer}, got70);
        end
      end
      start = 1'b0;
      bus.eng_done = (c == s + 2) ? (4'b0001 << tbl_m[0]) : 4'd0;
      srstn = (c == s + 6);
      rand_bus(); bus.eng_en_rd = 4'hF; bus.eng_en_wr = 4'hF;
    end
    srstn = 1'b0;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    program_table();
    test_basic();
    run_seq(0, 1'b0, 1'b0);
    test_random();
    test_cfg_frozen();
    test_timeout();
    for (int i = 0; i < ML; i++) lat_m[i] = $urandom_range(1, 6);
    run_seq(1, 1'b0, 1'b0);
    test_reset_mid();
    run_seq(3, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
